// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_pkg : shared decode constants and control bundle for ID/EX     |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Opcodes whose rt field is a true source operand (not a destination).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_ex_stage_if : IF/ID, regfile, writeback and ID/EX signal bundle  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              ifid_valid;
    logic [31:0]       ifid_instr;
    logic [31:0]       ifid_pc4;
    logic [REG_AW-1:0] REG_address1;
    logic [REG_AW-1:0] REG_address2;
    logic [DATA_W-1:0] REG_data_out1;
    logic [DATA_W-1:0] REG_data_out2;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              ex_stall;
    logic              if_hold;
    logic              hazard_stall;
    logic              idex_valid;
    logic [31:0]       idex_pc4;
    logic [DATA_W-1:0] idex_rs_data;
    logic [DATA_W-1:0] idex_rt_data;
    logic [DATA_W-1:0] idex_imm;
    logic [REG_AW-1:0] idex_rs;
    logic [REG_AW-1:0] idex_rt;
    logic [REG_AW-1:0] idex_dest;
    logic [2:0]        idex_alu_op;
    logic              idex_alu_src;
    logic              idex_reg_write;
    logic              idex_mem_read;
    logic              idex_mem_write;
    logic              idex_mem_to_reg;
    logic              idex_branch;
    logic              idex_illegal;

    modport slave (
        input  ifid_valid, ifid_instr, ifid_pc4, REG_data_out1, REG_data_out2,
               wb_we, wb_addr, wb_data, flush, ex_stall,
        output REG_address1, REG_address2, if_hold, hazard_stall,
               idex_valid, idex_pc4, idex_rs_data, idex_rt_data, idex_imm,
               idex_rs, idex_rt, idex_dest, idex_alu_op, idex_alu_src,
               idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg,
               idex_branch, idex_illegal
    );

    modport master (
        output ifid_valid, ifid_instr, ifid_pc4, REG_data_out1, REG_data_out2,
               wb_we, wb_addr, wb_data, flush, ex_stall,
        input  REG_address1, REG_address2, if_hold, hazard_stall,
               idex_valid, idex_pc4, idex_rs_data, idex_rt_data, idex_imm,
               idex_rs, idex_rt, idex_dest, idex_alu_op, idex_alu_src,
               idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg,
               idex_branch, idex_illegal
    );
endinterface
`default_nettype wire

// File: rtl/mips_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_decoder : combinational instruction -> control bundle + dest   |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module mips_decoder
    import mips_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic [4:0]  o_dest
);
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic [4:0] w_rd;

    assign w_op    = i_instr[31:26];
    assign w_funct = i_instr[5:0];
    assign w_rt    = i_instr[20:16];
    assign w_rd    = i_instr[15:11];

    always_comb begin
        o_ctrl = CTRL_NONE;
        o_dest = '0;
        case (w_op)
            OP_RTYPE: begin
                // The all-zero word is the canonical NOP: no controls, not illegal.
                if (i_instr != 32'd0) begin
                    o_ctrl.reg_write = 1'b1;
                    o_dest           = w_rd;
                    case (w_funct)
                        FUNCT_ADD: o_ctrl.alu_op = ALU_ADD;
                        FUNCT_SUB: o_ctrl.alu_op = ALU_SUB;
                        FUNCT_AND: o_ctrl.alu_op = ALU_AND;
                        FUNCT_OR:  o_ctrl.alu_op = ALU_OR;
                        FUNCT_SLT: o_ctrl.alu_op = ALU_SLT;
                        default: begin
                            o_ctrl         = CTRL_NONE;
                            o_ctrl.illegal = 1'b1;
                            o_dest         = '0;
                        end
                    endcase
                end
            end
            OP_LW: begin
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_dest            = w_rt;
            end
            OP_SW: begin
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_dest           = w_rt;
            end
            OP_BEQ: begin
                o_ctrl.alu_op = ALU_SUB;
                o_ctrl.branch = 1'b1;
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_ex_stage : decode, operand bypass, load-use hazard, ID/EX reg    |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic           clk,
    input  logic           rst,
    id_ex_stage_if.slave   bus
);
    logic [5:0]        w_op;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_imm;
    ctrl_t             w_ctrl;
    logic [4:0]        w_dec_dest;
    logic              w_hazard;
    logic              w_bubble;

    logic              r_valid;
    logic [31:0]       r_pc4;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_dest;
    ctrl_t             r_ctrl;

    assign w_op = bus.ifid_instr[31:26];
    assign w_rs = bus.ifid_instr[25:21];
    assign w_rt = bus.ifid_instr[20:16];
    assign w_imm = {{(DATA_W-16){bus.ifid_instr[15]}}, bus.ifid_instr[15:0]};

    assign bus.REG_address1 = w_rs;
    assign bus.REG_address2 = w_rt;

    // The regfile writes on the same edge we capture, so a matching WB write must be bypassed.
    function automatic logic [DATA_W-1:0] f_operand(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] rf_data,
        input logic              we,
        input logic [REG_AW-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (idx == '0)
            return '0;
        else if (we && (waddr == idx))
            return wdata;
        else
            return rf_data;
    endfunction

    assign w_rs_data = f_operand(w_rs, bus.REG_data_out1, bus.wb_we, bus.wb_addr, bus.wb_data);
    assign w_rt_data = f_operand(w_rt, bus.REG_data_out2, bus.wb_we, bus.wb_addr, bus.wb_data);

    mips_decoder u_dec (
        .i_instr (bus.ifid_instr),
        .o_ctrl  (w_ctrl),
        .o_dest  (w_dec_dest)
    );

    assign w_hazard = bus.ifid_valid & r_valid & r_ctrl.mem_read & (r_dest != '0) &
                      ((r_dest == w_rs) | ((r_dest == w_rt) & reads_rt(w_op)));
    assign w_bubble = bus.flush | w_hazard | ~bus.ifid_valid;

    assign bus.hazard_stall = w_hazard;
    assign bus.if_hold      = w_hazard | bus.ex_stall;

    always_ff @(posedge clk) begin
        if (rst || (!bus.ex_stall && w_bubble)) begin
            r_valid   <= 1'b0;
            r_pc4     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_ctrl    <= CTRL_NONE;
        end else if (!bus.ex_stall) begin
            r_valid   <= 1'b1;
            r_pc4     <= bus.ifid_pc4;
            r_rs_data <= w_rs_data;
            r_rt_data <= w_rt_data;
            r_imm     <= w_imm;
            r_rs      <= w_rs;
            r_rt      <= w_rt;
            r_dest    <= REG_AW'(w_dec_dest);
            r_ctrl    <= w_ctrl;
        end
    end

    assign bus.idex_valid      = r_valid;
    assign bus.idex_pc4        = r_pc4;
    assign bus.idex_rs_data    = r_rs_data;
    assign bus.idex_rt_data    = r_rt_data;
    assign bus.idex_imm        = r_imm;
    assign bus.idex_rs         = r_rs;
    assign bus.idex_rt         = r_rt;
    assign bus.idex_dest       = r_dest;
    assign bus.idex_alu_op     = r_ctrl.alu_op;
    assign bus.idex_alu_src    = r_ctrl.alu_src;
    assign bus.idex_reg_write  = r_ctrl.reg_write;
    assign bus.idex_mem_read   = r_ctrl.mem_read;
    assign bus.idex_mem_write  = r_ctrl.mem_write;
    assign bus.idex_mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.idex_branch     = r_ctrl.branch;
    assign bus.idex_illegal    = r_ctrl.illegal;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_id_ex_stage : directed vector table plus reset corner sequences  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // flag order: alu_src reg_write mem_read mem_write mem_to_reg branch illegal
    localparam logic [6:0] F_R    = 7'b0100000;
    localparam logic [6:0] F_LW   = 7'b1110100;
    localparam logic [6:0] F_SW   = 7'b1001000;
    localparam logic [6:0] F_ADDI = 7'b1100000;
    localparam logic [6:0] F_BEQ  = 7'b0000010;
    localparam logic [6:0] F_ILL  = 7'b0000001;

    localparam logic [31:0] ADD3   = 32'h00221820; // add  $3,$1,$2
    localparam logic [31:0] LW4    = 32'h8C240008; // lw   $4,8($1)
    localparam logic [31:0] ADD5   = 32'h00822820; // add  $5,$4,$2
    localparam logic [31:0] SUB7   = 32'h00C03822; // sub  $7,$6,$0
    localparam logic [31:0] ADD8   = 32'h00004020; // add  $8,$0,$0
    localparam logic [31:0] AND10  = 32'h00225024;
    localparam logic [31:0] OR11   = 32'h00225825;
    localparam logic [31:0] SLT12  = 32'h0022602A;
    localparam logic [31:0] SW2    = 32'hAC22FFFC; // sw   $2,-4($1)
    localparam logic [31:0] BEQ    = 32'h10220003;
    localparam logic [31:0] ADDI9  = 32'h20297FFF;
    localparam logic [31:0] ILL    = 32'hFC21FFFF; // opcode 0x3F
    localparam logic [31:0] ADDU   = 32'h00221821; // unsupported funct
    localparam logic [31:0] ADDI4  = 32'h20240001; // addi $4,$1,1
    localparam logic [31:0] LW0    = 32'h8C200000; // lw   $0,0($1)
    localparam logic [31:0] ADD3Z  = 32'h00021820; // add  $3,$0,$2
    localparam logic [31:0] SW4    = 32'hAC240000; // sw   $4,0($1)

    typedef struct packed {
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        wwe;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic        st;
        logic        hz;
        logic        bub;
        logic        v;
        logic [31:0] opc4;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [2:0]  op;
        logic [6:0]  flg;
    } vec_t;

    vec_t cur;
    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic S(input logic iv, input logic [31:0] instr, pc4, d1, d2,
                     input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                     input logic fl, st, hz);
        cur = '0;
        cur.iv = iv; cur.instr = instr; cur.pc4 = pc4; cur.d1 = d1; cur.d2 = d2;
        cur.wwe = wwe; cur.wa = wa; cur.wd = wd; cur.fl = fl; cur.st = st; cur.hz = hz;
    endtask

    task automatic E(input logic v, input logic [31:0] opc4, rsd, rtd, imm,
                     input logic [4:0] rs, rt, dest, input logic [2:0] op, input logic [6:0] flg);
        cur.v = v; cur.opc4 = opc4; cur.rsd = rsd; cur.rtd = rtd; cur.imm = imm;
        cur.rs = rs; cur.rt = rt; cur.dest = dest; cur.op = op; cur.flg = flg;
        tbl.push_back(cur);
    endtask

    task automatic B();
        cur.bub = 1'b1;
        tbl.push_back(cur);
    endtask

    // ID/EX must still hold what the previous row left there.
    task automatic H();
        vec_t p;
        p = tbl[$];
        cur.bub = p.bub; cur.v = p.v; cur.opc4 = p.opc4; cur.rsd = p.rsd; cur.rtd = p.rtd;
        cur.imm = p.imm; cur.rs = p.rs; cur.rt = p.rt; cur.dest = p.dest; cur.op = p.op; cur.flg = p.flg;
        tbl.push_back(cur);
    endtask

    function automatic logic [153:0] act_full();
        return {bus.idex_valid, bus.idex_pc4, bus.idex_rs_data, bus.idex_rt_data, bus.idex_imm,
                bus.idex_rs, bus.idex_rt, bus.idex_dest, bus.idex_alu_op,
                bus.idex_alu_src, bus.idex_reg_write, bus.idex_mem_read, bus.idex_mem_write,
                bus.idex_mem_to_reg, bus.idex_branch, bus.idex_illegal};
    endfunction

    function automatic logic [15:0] act_ctl();
        return {bus.idex_valid, bus.idex_dest, bus.idex_alu_op,
                bus.idex_alu_src, bus.idex_reg_write, bus.idex_mem_read, bus.idex_mem_write,
                bus.idex_mem_to_reg, bus.idex_branch, bus.idex_illegal};
    endfunction

    task automatic chk(input string name, input int idx, input logic [159:0] act, exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.ifid_valid    = t.iv;
        bus.ifid_instr    = t.instr;
        bus.ifid_pc4      = t.pc4;
        bus.REG_data_out1 = t.d1;
        bus.REG_data_out2 = t.d2;
        bus.wb_we         = t.wwe;
        bus.wb_addr       = t.wa;
        bus.wb_data       = t.wd;
        bus.flush         = t.fl;
        bus.ex_stall      = t.st;
    endtask

    initial begin
        vec_t t;
        // ---------------- table ----------------
        S(1, ADD3, 32'h104, 5, 7, 0, 0, 0, 0, 0, 0);            E(1, 32'h104, 5, 7, 32'h1820, 1, 2, 3, 0, F_R);
        S(1, LW4, 32'h108, 32'h100, 32'h44, 0, 0, 0, 0, 0, 0);  E(1, 32'h108, 32'h100, 32'h44, 8, 1, 4, 4, 0, F_LW);
        S(1, ADD5, 32'h10C, 32'h55, 7, 0, 0, 0, 0, 0, 1);       B();
        S(1, ADD5, 32'h10C, 32'h55, 7, 0, 0, 0, 0, 0, 0);       E(1, 32'h10C, 32'h55, 7, 32'h2820, 4, 2, 5, 0, F_R);
        S(1, SUB7, 32'h110, 32'h66, 32'h99, 1, 6, 32'hDEAD, 0, 0, 0); E(1, 32'h110, 32'hDEAD, 0, 32'h3822, 6, 0, 7, 1, F_R);
        S(1, ADD8, 32'h114, 32'h11, 32'h22, 1, 0, 32'h1234, 0, 0, 0); E(1, 32'h114, 0, 0, 32'h4020, 0, 0, 8, 0, F_R);
        S(1, AND10, 32'h118, 3, 9, 1, 2, 32'hBEEF, 0, 0, 0);    E(1, 32'h118, 3, 32'hBEEF, 32'h5024, 1, 2, 10, 2, F_R);
        S(1, OR11, 32'h11C, 32'hF0, 32'h0F, 0, 0, 0, 0, 0, 0);  E(1, 32'h11C, 32'hF0, 32'h0F, 32'h5825, 1, 2, 11, 3, F_R);
        S(1, SLT12, 32'h120, 1, 2, 0, 0, 0, 0, 0, 0);           E(1, 32'h120, 1, 2, 32'h602A, 1, 2, 12, 4, F_R);
        S(1, SW2, 32'h124, 32'h200, 32'hABCD, 0, 0, 0, 0, 0, 0); E(1, 32'h124, 32'h200, 32'hABCD, 32'hFFFFFFFC, 1, 2, 0, 0, F_SW);
        S(1, BEQ, 32'h128, 1, 1, 0, 0, 0, 0, 0, 0);             E(1, 32'h128, 1, 1, 3, 1, 2, 0, 1, F_BEQ);
        S(1, ADDI9, 32'h12C, 32'h10, 0, 0, 0, 0, 0, 0, 0);      E(1, 32'h12C, 32'h10, 0, 32'h7FFF, 1, 9, 9, 0, F_ADDI);
        S(1, ILL, 32'h130, 1, 1, 0, 0, 0, 0, 0, 0);             E(1, 32'h130, 1, 1, 32'hFFFFFFFF, 1, 1, 0, 0, F_ILL);
        S(1, ADDU, 32'h134, 5, 7, 0, 0, 0, 0, 0, 0);            E(1, 32'h134, 5, 7, 32'h1821, 1, 2, 0, 0, F_ILL);
        S(1, 32'h0, 32'h138, 0, 0, 0, 0, 0, 0, 0, 0);           E(1, 32'h138, 0, 0, 0, 0, 0, 0, 0, 7'b0);
        S(1, LW4, 32'h13C, 32'h100, 32'h44, 0, 0, 0, 0, 0, 0);  E(1, 32'h13C, 32'h100, 32'h44, 8, 1, 4, 4, 0, F_LW);
        S(1, ADDI4, 32'h140, 32'h100, 32'h44, 0, 0, 0, 0, 0, 0); E(1, 32'h140, 32'h100, 32'h44, 1, 1, 4, 4, 0, F_ADDI);
        S(1, LW0, 32'h144, 7, 8, 0, 0, 0, 0, 0, 0);             E(1, 32'h144, 7, 0, 0, 1, 0, 0, 0, F_LW);
        S(1, ADD3Z, 32'h148, 9, 7, 0, 0, 0, 0, 0, 0);           E(1, 32'h148, 0, 7, 32'h1820, 0, 2, 3, 0, F_R);
        S(1, LW4, 32'h14C, 32'h100, 32'h44, 0, 0, 0, 0, 0, 0);  E(1, 32'h14C, 32'h100, 32'h44, 8, 1, 4, 4, 0, F_LW);
        S(1, SW4, 32'h150, 1, 2, 0, 0, 0, 0, 0, 1);             B();
        S(1, SW4, 32'h150, 1, 2, 0, 0, 0, 0, 0, 0);             E(1, 32'h150, 1, 2, 0, 1, 4, 0, 0, F_SW);
        S(1, ADD3, 32'h154, 5, 7, 0, 0, 0, 0, 1, 0);            H();
        S(1, LW4, 32'h158, 32'h100, 32'h44, 0, 0, 0, 0, 1, 0);  H();
        S(1, ADDI9, 32'h15C, 32'h10, 0, 0, 0, 0, 0, 1, 0);      H();
        S(1, ADD3, 32'h154, 5, 7, 0, 0, 0, 1, 1, 0);            H();
        S(1, ADD3, 32'h154, 5, 7, 0, 0, 0, 1, 0, 0);            B();
        S(0, ADD3, 32'h154, 5, 7, 0, 0, 0, 0, 0, 0);            B();
        S(1, LW4, 32'h158, 32'h100, 32'h44, 0, 0, 0, 0, 0, 0);  E(1, 32'h158, 32'h100, 32'h44, 8, 1, 4, 4, 0, F_LW);
        S(1, ADD5, 32'h15C, 32'h55, 7, 0, 0, 0, 0, 1, 1);       H();
        S(1, ADD5, 32'h15C, 32'h55, 7, 0, 0, 0, 0, 0, 1);       B();
        S(1, ADD5, 32'h15C, 32'h55, 7, 0, 0, 0, 0, 0, 0);       E(1, 32'h15C, 32'h55, 7, 32'h2820, 4, 2, 5, 0, F_R);

        // ---------------- reset state ----------------
        rst = 1'b1;
        S(1, LW4, 32'h108, 32'h100, 32'h44, 0, 0, 0, 0, 0, 0);
        drive(cur);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 0, 160'(act_full()), 160'd0);
        chk("reset_hazard", 0, 160'(bus.hazard_stall), 160'd0);
        chk("reset_hold", 0, 160'(bus.if_hold), 160'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table loop ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            @(negedge clk);
            drive(t);
            #1;
            chk("hazard_stall", i, 160'(bus.hazard_stall), 160'(t.hz));
            chk("if_hold", i, 160'(bus.if_hold), 160'(t.hz | t.st));
            chk("reg_addr", i, 160'({bus.REG_address1, bus.REG_address2}), 160'({t.instr[25:21], t.instr[20:16]}));
            @(posedge clk);
            #1;
            if (t.bub)
                chk("idex_bubble", i, 160'(act_ctl()), 160'd0);
            else
                chk("idex_regs", i, 160'(act_full()),
                    160'({t.v, t.opc4, t.rsd, t.rtd, t.imm, t.rs, t.rt, t.dest, t.op, t.flg}));
        end

        // ---------------- reset with a load sitting in ID/EX ----------------
        @(negedge clk);
        S(1, LW4, 32'h200, 32'h100, 32'h44, 0, 0, 0, 0, 0, 0);
        drive(cur);
        @(posedge clk);
        #1;
        chk("mid_lw_loaded", 0, 160'(bus.idex_mem_read), 160'd1);
        @(negedge clk);
        S(1, ADD5, 32'h204, 32'h55, 7, 0, 0, 0, 0, 0, 0);
        drive(cur);
        rst = 1'b1;
        #1;
        chk("mid_hazard_pre", 0, 160'(bus.hazard_stall), 160'd1);
        @(posedge clk);
        #1;
        chk("mid_reset_outputs", 0, 160'(act_full()), 160'd0);
        chk("mid_reset_hazard", 0, 160'(bus.hazard_stall), 160'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
